// File: rtl/fsm_gen_route_if.sv
// Pad-side bundle of the fsm_gen_route step machine.
// Signals:
//   in_Pad         advance channels, one count per asserted bit
//   ret_Pad        retreat channel, counts -1
//   state_obs_Pad  current state index (registered in the design)
//   output1_Pad    one-cycle flag: emit state just entered
//   bound_Pad      one-cycle flag: last step wrapped or clamped
// Modports: master drives the channels and observes the state;
//           slave is the state machine itself.
interface fsm_gen_route_if #(
    parameter int N_IN    = 2,
    parameter int STATE_W = 2
);
    logic [N_IN-1:0]    in_Pad;
    logic               ret_Pad;
    logic [STATE_W-1:0] state_obs_Pad;
    logic               output1_Pad;
    logic               bound_Pad;

    modport master (
        output in_Pad,
        output ret_Pad,
        input  state_obs_Pad,
        input  output1_Pad,
        input  bound_Pad
    );

    modport slave (
        input  in_Pad,
        input  ret_Pad,
        output state_obs_Pad,
        output output1_Pad,
        output bound_Pad
    );
endinterface

// File: rtl/fsm_gen_route.sv
// Parametrised pulse-step state machine.
// Each rising GCLK_Pad edge moves the state index by
// popcount(in_Pad) - ret_Pad. The index either wraps modulo N_STATES
// (WRAP=1) or saturates at 0 / N_STATES-1 (WRAP=0).
// Ports:
//   GCLK_Pad   clock, rising edge
//   reset_Pad  synchronous active-high reset
//   bus        fsm_gen_route_if slave: in_Pad, ret_Pad in;
//              state_obs_Pad, output1_Pad, bound_Pad out (all registered)
module fsm_gen_route #(
    parameter int N_STATES   = 4,
    parameter int N_IN       = 2,
    parameter int WRAP       = 1,
    parameter int EMIT_STATE = 3
) (
    input  logic           GCLK_Pad,
    input  logic           reset_Pad,
    fsm_gen_route_if.slave bus
);
    localparam int STATE_W = (N_STATES > 2) ? $clog2(N_STATES) : 1;
    // Five extra bits hold the step range -1..8 plus sign without overflow.
    localparam int SW = STATE_W + 5;

    localparam logic signed [SW-1:0]   NS_S   = SW'(N_STATES);
    localparam logic signed [SW-1:0]   TOP_S  = SW'(N_STATES - 1);
    localparam logic signed [SW-1:0]   ZERO_S = {SW{1'b0}};
    localparam logic [SW-1:0]          NS_U   = SW'(N_STATES);
    localparam logic [STATE_W-1:0]     EMIT_C = STATE_W'(EMIT_STATE);
    localparam logic [STATE_W-1:0]     IDX0_C = {STATE_W{1'b0}};

    // Number of asserted advance channels, widened to the arithmetic width.
    function automatic logic [SW-1:0] popcount_f(input logic [N_IN-1:0] v);
        logic [SW-1:0] cnt;
        cnt = {SW{1'b0}};
        for (int i = 0; i < N_IN; i++) begin
            cnt = cnt + {{(SW-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    logic [STATE_W-1:0]    state_r;
    logic                  out1_r;
    logic                  bound_r;

    logic [SW-1:0]         state_ext_s;
    logic signed [SW-1:0]  step_s;
    logic signed [SW-1:0]  raw_s;
    logic signed [SW-1:0]  fixed_s;
    logic                  corr_s;
    logic                  in_range_s;
    logic [STATE_W-1:0]    next_state_s;
    logic                  emit_s;

    // Next-state arithmetic: step, wrap/clamp correction and flag generation.
    always_comb begin
        state_ext_s  = {5'b00000, state_r};
        in_range_s   = (state_ext_s < NS_U);
        step_s       = $signed(popcount_f(bus.in_Pad))
                     - $signed({{(SW-1){1'b0}}, bus.ret_Pad});
        raw_s        = $signed(state_ext_s) + step_s;
        fixed_s      = raw_s;
        corr_s       = 1'b0;
        next_state_s = IDX0_C;
        emit_s       = 1'b0;

        if (WRAP != 0) begin
            // One add/subtract of N_STATES brings raw back into range.
            if (raw_s < ZERO_S) begin
                fixed_s = raw_s + NS_S;
                corr_s  = 1'b1;
            end else if (raw_s >= NS_S) begin
                fixed_s = raw_s - NS_S;
                corr_s  = 1'b1;
            end else begin
                fixed_s = raw_s;
                corr_s  = 1'b0;
            end
        end else begin
            if (raw_s < ZERO_S) begin
                fixed_s = ZERO_S;
                corr_s  = 1'b1;
            end else if (raw_s > TOP_S) begin
                fixed_s = TOP_S;
                corr_s  = 1'b1;
            end else begin
                fixed_s = raw_s;
                corr_s  = 1'b0;
            end
        end

        if (in_range_s) begin
            next_state_s = STATE_W'(fixed_s);
            // A landing that leaves the index unchanged (hold or full wrap) is not an entry.
            emit_s       = (next_state_s == EMIT_C) && (next_state_s != state_r);
        end else begin
            // Illegal index: recover to 0 quietly.
            next_state_s = IDX0_C;
            corr_s       = 1'b0;
            emit_s       = 1'b0;
        end
    end

    // State and flag registers with synchronous reset.
    always_ff @(posedge GCLK_Pad) begin
        if (reset_Pad) begin
            state_r <= IDX0_C;
            out1_r  <= 1'b0;
            bound_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            out1_r  <= emit_s;
            bound_r <= corr_s;
        end
    end

    assign bus.state_obs_Pad = state_r;
    assign bus.output1_Pad   = out1_r;
    assign bus.bound_Pad     = bound_r;
endmodule

// File: tb/tb_fsm_gen_route.sv
// Scoreboard bench for fsm_gen_route with three parameter sets:
//   d0: defaults (4 states, 2 inputs, wrap, emit 3)
//   d1: WRAP=0, otherwise defaults
//   d2: 5 states, 3 inputs, wrap, emit 0
module tb_fsm_gen_route;
    typedef struct {
        int st;
        int o1;
        int bd;
    } exp_t;

    logic clk;
    logic rst0, rst1, rst2;
    int   errors;
    int   checks;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   m0, m1, m2;

    fsm_gen_route_if #(.N_IN(2), .STATE_W(2)) if0 ();
    fsm_gen_route_if #(.N_IN(2), .STATE_W(2)) if1 ();
    fsm_gen_route_if #(.N_IN(3), .STATE_W(3)) if2 ();

    fsm_gen_route #(.N_STATES(4), .N_IN(2), .WRAP(1), .EMIT_STATE(3)) u_d0 (
        .GCLK_Pad(clk), .reset_Pad(rst0), .bus(if0));
    fsm_gen_route #(.N_STATES(4), .N_IN(2), .WRAP(0), .EMIT_STATE(3)) u_d1 (
        .GCLK_Pad(clk), .reset_Pad(rst1), .bus(if1));
    fsm_gen_route #(.N_STATES(5), .N_IN(3), .WRAP(1), .EMIT_STATE(0)) u_d2 (
        .GCLK_Pad(clk), .reset_Pad(rst2), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference: true modulo / clamp on integers.
    function automatic exp_t model(input int st, input int pc, input int rt,
                                   input int ns, input int wrap, input int emit);
        exp_t e;
        int   raw;
        int   nxt;
        raw = st + pc - rt;
        if (wrap != 0) nxt = ((raw % ns) + ns) % ns;
        else nxt = (raw < 0) ? 0 : ((raw > ns - 1) ? ns - 1 : raw);
        e.st = nxt;
        e.bd = (nxt != raw) ? 1 : 0;
        e.o1 = (nxt == emit && nxt != st) ? 1 : 0;
        return e;
    endfunction

    task automatic push0(input logic r, input logic [1:0] i, input logic rt,
                         input int st, input int o1, input int bd);
        exp_t e;
        rst0 = r; if0.in_Pad = i; if0.ret_Pad = rt;
        e.st = st; e.o1 = o1; e.bd = bd;
        q0.push_back(e);
    endtask

    task automatic push1(input logic r, input logic [1:0] i, input logic rt,
                         input int st, input int o1, input int bd);
        exp_t e;
        rst1 = r; if1.in_Pad = i; if1.ret_Pad = rt;
        e.st = st; e.o1 = o1; e.bd = bd;
        q1.push_back(e);
    endtask

    task automatic push2(input logic r, input logic [2:0] i, input logic rt,
                         input int st, input int o1, input int bd);
        exp_t e;
        rst2 = r; if2.in_Pad = i; if2.ret_Pad = rt;
        e.st = st; e.o1 = o1; e.bd = bd;
        q2.push_back(e);
    endtask

    task automatic idle_inputs();
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        if0.in_Pad = 2'b00; if0.ret_Pad = 1'b0;
        if1.in_Pad = 2'b00; if1.ret_Pad = 1'b0;
        if2.in_Pad = 3'b000; if2.ret_Pad = 1'b0;
    endtask

    // One edge: outputs are sampled 1 time unit after it and matched to the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check_eq("d0_state", int'(if0.state_obs_Pad), e.st);
            check_eq("d0_out1", int'(if0.output1_Pad), e.o1);
            check_eq("d0_bound", int'(if0.bound_Pad), e.bd);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check_eq("d1_state", int'(if1.state_obs_Pad), e.st);
            check_eq("d1_out1", int'(if1.output1_Pad), e.o1);
            check_eq("d1_bound", int'(if1.bound_Pad), e.bd);
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check_eq("d2_state", int'(if2.state_obs_Pad), e.st);
            check_eq("d2_out1", int'(if2.output1_Pad), e.o1);
            check_eq("d2_bound", int'(if2.bound_Pad), e.bd);
        end
        idle_inputs();
    endtask

    initial begin
        exp_t e;
        logic        r;
        logic [1:0]  i2;
        logic [2:0]  i3;
        logic        rt;
        errors = 0;
        checks = 0;
        idle_inputs();

        // Reset wins over active inputs on all three.
        push0(1'b1, 2'b11, 1'b0, 0, 0, 0);
        push1(1'b1, 2'b11, 1'b1, 0, 0, 0);
        push2(1'b1, 3'b111, 1'b0, 0, 0, 0);
        tick();

        // d0: count up to the emit state, then hold.
        push0(1'b0, 2'b01, 1'b0, 1, 0, 0); tick();
        push0(1'b0, 2'b01, 1'b0, 2, 0, 0); tick();
        push0(1'b0, 2'b01, 1'b0, 3, 1, 0); tick();
        push0(1'b0, 2'b00, 1'b0, 3, 0, 0); tick();
        // d0: wrap 3 -> 1, then advance+retreat cancels.
        push0(1'b0, 2'b11, 1'b0, 1, 0, 1); tick();
        push0(1'b0, 2'b01, 1'b1, 1, 0, 0); tick();
        // d0: retreat from 0 wraps onto the emit state: both flags.
        push0(1'b1, 2'b00, 1'b0, 0, 0, 0); tick();
        push0(1'b0, 2'b00, 1'b1, 3, 1, 1); tick();
        // d0: mid-sequence reset at state 2.
        push0(1'b1, 2'b00, 1'b0, 0, 0, 0); tick();
        push0(1'b0, 2'b11, 1'b0, 2, 0, 0); tick();
        push0(1'b1, 2'b01, 1'b0, 0, 0, 0); tick();
        push0(1'b0, 2'b01, 1'b0, 1, 0, 0); tick();

        // d1: saturating variant.
        push1(1'b0, 2'b00, 1'b1, 0, 0, 1); tick();
        push1(1'b0, 2'b11, 1'b0, 2, 0, 0); tick();
        push1(1'b0, 2'b11, 1'b0, 3, 1, 1); tick();
        push1(1'b0, 2'b01, 1'b0, 3, 0, 1); tick();
        push1(1'b0, 2'b00, 1'b0, 3, 0, 0); tick();

        // d2: five states, emit at 0.
        push2(1'b0, 3'b111, 1'b0, 3, 0, 0); tick();
        push2(1'b0, 3'b001, 1'b0, 4, 0, 0); tick();
        push2(1'b0, 3'b111, 1'b0, 2, 0, 1); tick();
        push2(1'b0, 3'b011, 1'b0, 4, 0, 0); tick();
        push2(1'b0, 3'b001, 1'b0, 0, 1, 1); tick();
        // Step over 0 (3 -> 1) without landing: no emit.
        push2(1'b0, 3'b111, 1'b0, 3, 0, 0); tick();
        push2(1'b0, 3'b111, 1'b0, 1, 0, 1); tick();

        // Random phase against the integer model, starting from reset.
        push0(1'b1, 2'b00, 1'b0, 0, 0, 0);
        push1(1'b1, 2'b00, 1'b0, 0, 0, 0);
        push2(1'b1, 3'b000, 1'b0, 0, 0, 0);
        tick();
        m0 = 0; m1 = 0; m2 = 0;
        for (int n = 0; n < 300; n++) begin
            r  = ($urandom_range(0, 15) == 0);
            i2 = 2'($urandom_range(0, 3));
            rt = 1'($urandom_range(0, 1));
            if (r) begin e.st = 0; e.o1 = 0; e.bd = 0; end
            else e = model(m0, $countones(i2), int'(rt), 4, 1, 3);
            push0(r, i2, rt, e.st, e.o1, e.bd);
            m0 = e.st;

            r  = ($urandom_range(0, 15) == 0);
            i2 = 2'($urandom_range(0, 3));
            rt = 1'($urandom_range(0, 1));
            if (r) begin e.st = 0; e.o1 = 0; e.bd = 0; end
            else e = model(m1, $countones(i2), int'(rt), 4, 0, 3);
            push1(r, i2, rt, e.st, e.o1, e.bd);
            m1 = e.st;

            r  = ($urandom_range(0, 15) == 0);
            i3 = 3'($urandom_range(0, 7));
            rt = 1'($urandom_range(0, 1));
            if (r) begin e.st = 0; e.o1 = 0; e.bd = 0; end
            else e = model(m2, $countones(i3), int'(rt), 5, 1, 0);
            push2(r, i3, rt, e.st, e.o1, e.bd);
            m2 = e.st;

            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
